rib_arbiter: RTL

RIB_ARBITER -- requirements
Module: rib_arbiter

---
 rtl/rib_arbiter_pkg.sv | 28 ++
 rtl/rib_rr_pick.sv | 36 +++
 rtl/rib_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rib_arbiter_pkg.sv
// Shared constants for the RIB bus arbiter: state encodings, master index
// constants, default watchdog limit and a one-hot to index helper.
package rib_arbiter_pkg;

   localparam int unsigned RIB_NUM_M       = 4;
   localparam int unsigned RIB_ID_W        = 2;
   localparam int unsigned RIB_TIMEOUT_DEF = 255;

   localparam logic [RIB_ID_W-1:0] M0_ID = 2'd0;
   localparam logic [RIB_ID_W-1:0] M1_ID = 2'd1;
   localparam logic [RIB_ID_W-1:0] M2_ID = 2'd2;
   localparam logic [RIB_ID_W-1:0] M3_ID = 2'd3;   // debug master

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } rib_state_e;

   function automatic logic [RIB_ID_W-1:0] onehot_to_id(input logic [RIB_NUM_M-1:0] oh);
      logic [RIB_ID_W-1:0] id;
      id = '0;
      for (int i = 0; i < RIB_NUM_M; i++) begin
         if (oh[i]) id = id | RIB_ID_W'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/rib_rr_pick.sv
// Combinational winner search: round-robin upward from last_owner+1, with an
// optional absolute override for the debug master.
module rib_rr_pick
   import rib_arbiter_pkg::*;
(
   input  logic [RIB_NUM_M-1:0] req,
   input  logic [RIB_ID_W-1:0]  last_owner,
   input  logic [RIB_NUM_M-1:0] mask,
   input  logic                 m3_prio,
   output logic [RIB_NUM_M-1:0] winner
);

   logic [RIB_NUM_M-1:0] w_cand;
   logic [RIB_ID_W-1:0]  w_idx;
   logic                 w_found;

   always_comb begin
      w_cand  = req & mask;
      winner  = '0;
      w_idx   = '0;
      w_found = 1'b0;
      if (m3_prio && w_cand[M3_ID]) begin
         winner[M3_ID] = 1'b1;
      end else begin
         // Offset RIB_NUM_M wraps back to last_owner itself, so it is tried last.
         for (int k = 1; k <= RIB_NUM_M; k++) begin
            w_idx = last_owner + RIB_ID_W'(k);
            if (!w_found && w_cand[w_idx]) begin
               winner[w_idx] = 1'b1;
               w_found       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rib_arbiter.sv
// Four-master RIB bus arbiter with round-robin order, bus lock and debug-master
// priority. The ownership watchdog is built only when RIB_ARB_TIMEOUT_EN is defined.
module rib_arbiter
   import rib_arbiter_pkg::*;
#(
   parameter int unsigned NUM_M       = RIB_NUM_M,
   parameter int unsigned TIMEOUT_CYC = RIB_TIMEOUT_DEF,
   parameter int unsigned M3_PRIO     = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M-1:0]    req_i,
   input  logic [NUM_M-1:0]    lock_i,
   input  logic                ack_i,
   output logic [NUM_M-1:0]    grant_o,
   output logic [RIB_ID_W-1:0] grant_id_o,
   output logic                grant_vld_o,
   output logic                hold_flag_o,
   output logic                timeout_o,
   output logic [RIB_ID_W-1:0] err_id_o
);

   rib_state_e          r_state, w_state_nx;
   logic [NUM_M-1:0]    r_grant, w_grant_nx, w_winner, w_pick_mask;
   logic [RIB_ID_W-1:0] r_grant_id, r_last_owner, w_last_nx, w_pick_last;
   logic                r_grant_vld;
   logic                w_keep, w_release, w_to_fire;

   // While busy the search starts after the owner and never re-selects it.
   assign w_pick_last = (r_state == ST_BUSY) ? r_grant_id : r_last_owner;
   assign w_pick_mask = (r_state == ST_BUSY) ? ~r_grant : '1;

   rib_rr_pick u_pick (
      .req        (req_i),
      .last_owner (w_pick_last),
      .mask       (w_pick_mask),
      .m3_prio    (M3_PRIO != 0),
      .winner     (w_winner)
   );

   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_last_nx  = r_last_owner;
      w_keep     = 1'b0;
      w_release  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|req_i) begin
               w_grant_nx = w_winner;
               w_state_nx = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_keep    = ack_i & lock_i[r_grant_id] & req_i[r_grant_id];
            w_release = (ack_i & ~w_keep) | (~ack_i & ~req_i[r_grant_id]) | w_to_fire;
            if (w_release) begin
               w_last_nx  = r_grant_id;
               w_grant_nx = w_winner;
               w_state_nx = (|w_winner) ? ST_BUSY : ST_IDLE;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_grant_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_grant_id   <= '0;
         r_grant_vld  <= 1'b0;
         r_last_owner <= M3_ID;
      end else begin
         r_state      <= w_state_nx;
         r_grant      <= w_grant_nx;
         r_grant_id   <= onehot_to_id(w_grant_nx);
         r_grant_vld  <= |w_grant_nx;
         r_last_owner <= w_last_nx;
      end
   end

`ifdef RIB_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0]    r_to_cnt;
   logic                r_timeout;
   logic [RIB_ID_W-1:0] r_err_id;

   // A dropped request is an ordinary abort, not a watchdog event.
   assign w_to_fire = (r_state == ST_BUSY) & ~ack_i & req_i[r_grant_id] &
                      (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
         r_err_id  <= '0;
      end else begin
         r_timeout <= w_to_fire;
         if (w_to_fire) r_err_id <= r_grant_id;
         if ((r_state != ST_BUSY) || ack_i || w_release) r_to_cnt <= '0;
         else                                            r_to_cnt <= r_to_cnt + CNT_W'(1);
      end
   end

   assign timeout_o = r_timeout;
   assign err_id_o  = r_err_id;
`else
   logic w_unused_cfg;

   assign w_to_fire    = 1'b0;
   assign timeout_o    = 1'b0;
   assign err_id_o     = '0;
   assign w_unused_cfg = ^8'(TIMEOUT_CYC);
`endif

   assign grant_o     = r_grant;
   assign grant_id_o  = r_grant_id;
   assign grant_vld_o = r_grant_vld;
   assign hold_flag_o = |(req_i & ~r_grant);

endmodule
